// File: rtl/vga_layer_compositor_pkg.sv
// Shared constants and helpers for the VGA layer compositor.
// Optional feature macro used by this codebase: SPRITE_HFLIP_EN (horizontal sprite mirroring).
package vga_layer_compositor_pkg;

    // Screen coordinate width (hCount / vCount / sprite positions)
    localparam int COORD_W = 10;

    // Colour constants (12-bit RGB, 4 bits per channel)
    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] GREEN = 12'h0F0;

    // Default transparent colour keys of the sprite ROMs
    localparam logic [11:0] KEY0_DEFAULT = 12'h00C;
    localparam logic [11:0] KEY1_DEFAULT = 12'h00D;
    localparam logic [11:0] KEY2_DEFAULT = 12'h00F;

    // Visible area of the 640x480 mode
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Number of offset bits needed to index one sprite dimension (dim is a power of 2)
    function automatic int sprite_bits(input int dim);
        return $clog2(dim);
    endfunction

    // True when a ROM pixel matches one of the transparent colour keys
    function automatic logic is_colour_key(input logic [11:0] px,
                                           input logic [11:0] k0,
                                           input logic [11:0] k1,
                                           input logic [11:0] k2);
        return (px == k0) || (px == k1) || (px == k2);
    endfunction

endpackage

// File: rtl/vga_layer_compositor_sprite_region_calc.sv
// One sprite layer: frame-shadowed position, region test and ROM address generation.
// With SPRITE_HFLIP_EN defined the flip request is shadowed too and mirrors the column offset.
module vga_layer_compositor_sprite_region_calc
    import vga_layer_compositor_pkg::*;
#(
    parameter int SPRITE_W = 128,
    parameter int SPRITE_H = 128,
    parameter int ADDR_W   = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] h,
    input  logic [COORD_W-1:0] v,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               flip,
    output logic               region,
    output logic [ADDR_W-1:0]  addr
);

    localparam int DX_W = sprite_bits(SPRITE_W);
    localparam int DY_W = sprite_bits(SPRITE_H);

    logic                 load;
    logic [COORD_W-1:0]   shadow_x;
    logic [COORD_W-1:0]   shadow_y;
    logic [COORD_W-1:0]   eff_x;
    logic [COORD_W-1:0]   eff_y;
    logic                 eff_flip;
    logic [COORD_W:0]     x_lo, x_hi, y_lo, y_hi, h_ext, v_ext;
    logic                 in_region;
    logic [DX_W-1:0]      dx;
    logic [DX_W-1:0]      dx_sel;
    logic [DY_W-1:0]      dy;

    // The frame_start pixel already sees the new positions so the whole frame is consistent.
    assign load  = pix_en & frame_start;
    assign eff_x = load ? pos_x : shadow_x;
    assign eff_y = load ? pos_y : shadow_y;

    // Shadow position registers, reloaded only at the start of a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_x <= '0;
            shadow_y <= '0;
        end else if (load) begin
            shadow_x <= pos_x;
            shadow_y <= pos_y;
        end
    end

`ifdef SPRITE_HFLIP_EN
    logic shadow_flip;

    // Shadow flip request, latched together with the position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_flip <= 1'b0;
        end else if (load) begin
            shadow_flip <= flip;
        end
    end

    assign eff_flip = load ? flip : shadow_flip;
`else
    logic flip_unused;
    assign flip_unused = flip;
    assign eff_flip    = 1'b0;
`endif

    // Region test in 11 bits so a sprite crossing column 1023 does not wrap to column 0
    always_comb begin
        h_ext     = {1'b0, h};
        v_ext     = {1'b0, v};
        x_lo      = {1'b0, eff_x};
        y_lo      = {1'b0, eff_y};
        x_hi      = x_lo + (COORD_W+1)'(SPRITE_W);
        y_hi      = y_lo + (COORD_W+1)'(SPRITE_H);
        in_region = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);
        // Only the low offset bits matter; they depend only on the low coordinate bits
        dx        = h[DX_W-1:0] - eff_x[DX_W-1:0];
        dy        = v[DY_W-1:0] - eff_y[DY_W-1:0];
        dx_sel    = eff_flip ? ~dx : dx;
    end

    // Registered region flag and ROM address (zero outside the sprite)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            region <= 1'b0;
            addr   <= '0;
        end else if (pix_en) begin
            region <= in_region;
            addr   <= in_region ? ADDR_W'({dy, dx_sel}) : '0;
        end
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// Pipelined compositor: sprite layers, HUD bar and sky/ground background into one 12-bit RGB.
// Stage S0 registers region/address and pixel context, S1 resolves priority, S2 registers rgb.
// Optional feature macro: SPRITE_HFLIP_EN (per-sprite horizontal mirroring, frame-shadowed).
module vga_layer_compositor
    import vga_layer_compositor_pkg::*;
#(
    parameter int          NUM_SPRITES = 2,
    parameter int          SPRITE_W    = 128,
    parameter int          SPRITE_H    = 128,
    parameter int          ADDR_W      = 14,
    parameter int          HORIZON     = 394,
    parameter logic [11:0] KEY0        = KEY0_DEFAULT,
    parameter logic [11:0] KEY1        = KEY1_DEFAULT,
    parameter logic [11:0] KEY2        = KEY2_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_en,
    input  logic                          bright,
    input  logic [9:0]                    hCount,
    input  logic [9:0]                    vCount,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          frame_start,
    input  logic [10*NUM_SPRITES-1:0]     sprite_x,
    input  logic [10*NUM_SPRITES-1:0]     sprite_y,
    input  logic [NUM_SPRITES-1:0]        sprite_flip,
    output logic [ADDR_W*NUM_SPRITES-1:0] sprite_addr,
    input  logic [12*NUM_SPRITES-1:0]     sprite_pixel,
    input  logic                          bar_draw,
    input  logic [11:0]                   bar_pixel,
    output logic [11:0]                   rgb,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [15:0]                   overlap_count,
    output logic                          overlap_hit
);

    // S0 context registered alongside the sprite addresses
    logic [NUM_SPRITES-1:0] region_s0;
    logic                   valid_s0;
    logic                   bright_s0;
    logic                   h4_s0;
    logic [9:0]             v_s0;
    logic                   bar_draw_s0;
    logic [11:0]            bar_pixel_s0;
    logic                   hs_s0;
    logic                   vs_s0;
    logic                   fs_s0;

    // S1 combinational results
    logic [2:0]             n_opaque;
    logic                   sprite_hit;
    logic [11:0]            sprite_colour;
    logic [3:0]             sky_blue;
    logic [3:0]             ground_green;
    logic [11:0]            colour_s1;
    logic                   overlap_now;

    logic [15:0]            running;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            vga_layer_compositor_sprite_region_calc #(
                .SPRITE_W (SPRITE_W),
                .SPRITE_H (SPRITE_H),
                .ADDR_W   (ADDR_W)
            ) u_region (
                .clk         (clk),
                .rst         (rst),
                .pix_en      (pix_en),
                .frame_start (frame_start),
                .h           (hCount),
                .v           (vCount),
                .pos_x       (sprite_x[10*gi +: 10]),
                .pos_y       (sprite_y[10*gi +: 10]),
                .flip        (sprite_flip[gi]),
                .region      (region_s0[gi]),
                .addr        (sprite_addr[ADDR_W*gi +: ADDR_W])
            );
        end
    endgenerate

    // S0: pixel context travelling with the sprite address fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s0     <= 1'b0;
            bright_s0    <= 1'b0;
            h4_s0        <= 1'b0;
            v_s0         <= '0;
            bar_draw_s0  <= 1'b0;
            bar_pixel_s0 <= '0;
            hs_s0        <= 1'b1;
            vs_s0        <= 1'b1;
            fs_s0        <= 1'b0;
        end else if (pix_en) begin
            valid_s0     <= 1'b1;
            bright_s0    <= bright;
            h4_s0        <= hCount[4];
            v_s0         <= vCount;
            bar_draw_s0  <= bar_draw;
            bar_pixel_s0 <= bar_pixel;
            hs_s0        <= hsync_in;
            vs_s0        <= vsync_in;
            fs_s0        <= frame_start;
        end
    end

    // S1: opaque sprite count and highest-priority (lowest index) opaque colour
    always_comb begin
        n_opaque      = '0;
        sprite_hit    = 1'b0;
        sprite_colour = BLACK;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (region_s0[i] && !is_colour_key(sprite_pixel[12*i +: 12], KEY0, KEY1, KEY2)) begin
                n_opaque      = n_opaque + 3'd1;
                sprite_hit    = 1'b1;
                sprite_colour = sprite_pixel[12*i +: 12];
            end
        end
    end

    // S1: layer priority mux with procedural background
    always_comb begin
        sky_blue     = (v_s0[9:4] > 6'd15) ? 4'hF : v_s0[7:4];
        ground_green = (h4_s0 ^ v_s0[3]) ? 4'hC : 4'h8;
        colour_s1    = BLACK;
        if (!bright_s0) begin
            colour_s1 = BLACK;
        end else if (bar_draw_s0) begin
            colour_s1 = bar_pixel_s0;
        end else if (sprite_hit) begin
            colour_s1 = sprite_colour;
        end else if (v_s0 < 10'(HORIZON)) begin
            colour_s1 = {8'h00, sky_blue};
        end else begin
            colour_s1 = {4'h0, ground_green, 4'h1};
        end
        overlap_now = valid_s0 && bright_s0 && (NUM_SPRITES > 1) && (n_opaque >= 3'd2);
    end

    // S2: output colour and matching sync delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb       <= BLACK;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else if (pix_en) begin
            rgb       <= valid_s0 ? colour_s1 : BLACK;
            hsync_out <= hs_s0;
            vsync_out <= vs_s0;
        end
    end

    // Overlap counter: saturating running count, published when frame_start reaches S1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running       <= '0;
            overlap_count <= '0;
            overlap_hit   <= 1'b0;
        end else if (pix_en && valid_s0) begin
            if (fs_s0) begin
                overlap_count <= running;
                overlap_hit   <= (running != 16'd0);
                running       <= overlap_now ? 16'd1 : 16'd0;
            end else if (overlap_now && (running != 16'hFFFF)) begin
                running <= running + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor (NUM_SPRITES=2, 128x128 sprites).
// Sprite ROMs are modelled as constant-colour sources; flip checks follow SPRITE_HFLIP_EN.
module tb_vga_layer_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        bright;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_start;
    logic [19:0] sprite_x;
    logic [19:0] sprite_y;
    logic [1:0]  sprite_flip;
    logic [27:0] sprite_addr;
    logic [23:0] sprite_pixel;
    logic        bar_draw;
    logic [11:0] bar_pixel;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic [15:0] overlap_count;
    logic        overlap_hit;

    logic [11:0] rom0;
    logic [11:0] rom1;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    assign sprite_pixel = {rom1, rom0};

    vga_layer_compositor dut (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (pix_en),
        .bright        (bright),
        .hCount        (hCount),
        .vCount        (vCount),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .frame_start   (frame_start),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_flip   (sprite_flip),
        .sprite_addr   (sprite_addr),
        .sprite_pixel  (sprite_pixel),
        .bar_draw      (bar_draw),
        .bar_pixel     (bar_pixel),
        .rgb           (rgb),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .overlap_count (overlap_count),
        .overlap_hit   (overlap_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel: a single pix_en edge, then three idle clocks (1-in-4 pixel rate)
    task automatic px(input int h, input int v, input logic b, input logic fs);
        @(negedge clk);
        hCount      = 10'(h);
        vCount      = 10'(v);
        bright      = b;
        frame_start = fs;
        pix_en      = 1'b1;
        @(negedge clk);
        pix_en      = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drive a pixel, advance one more pixel, then rgb holds that pixel's colour
    task automatic show(input string tag, input int h, input int v, input logic b,
                        input logic [11:0] exp);
        px(h, v, b, 1'b0);
        px(h, v, 1'b0, 1'b0);
        check(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic set_pos(input int x0, input int y0, input int x1, input int y1);
        sprite_x = {10'(x1), 10'(x0)};
        sprite_y = {10'(y1), 10'(y0)};
    endtask

    // frame_start pixel at (0,0) plus one pixel so it reaches S1
    task automatic new_frame();
        px(0, 0, 1'b0, 1'b1);
        px(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; bright = 1'b0; hCount = '0; vCount = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0;
        sprite_flip = 2'b00; bar_draw = 1'b0; bar_pixel = 12'h000;
        rom0 = 12'hF00; rom1 = 12'h0F0;
        set_pos(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(rgb), 'h000);
        check("rst_hsync", 32'(hsync_out), 'h1);
        check("rst_vsync", 32'(vsync_out), 'h1);
        check("rst_count", 32'(overlap_count), 'h0);
        check("rst_hit", 32'(overlap_hit), 'h0);
        check("rst_addr", 32'(sprite_addr), 'h0);
        rst = 1'b0;

        // Frame 1: sprite0 at (100,200), sprite1 at (100,50)
        set_pos(100, 200, 100, 50);
        new_frame();
        show("s0_top_left", 100, 200, 1'b1, 12'hF00);
        show("s0_bot_right", 227, 327, 1'b1, 12'hF00);
        show("s0_right_out", 228, 200, 1'b1, 12'h00C);
        show("s0_left_out", 99, 200, 1'b1, 12'h00C);
        show("s0_above_out", 100, 199, 1'b1, 12'h00C);
        show("s0_below_out", 100, 328, 1'b1, 12'h00F);
        show("dark", 150, 250, 1'b0, 12'h000);
        px(101, 202, 1'b1, 1'b0);
        check("addr0_in", 32'(sprite_addr[13:0]), 257);
        check("addr1_out", 32'(sprite_addr[27:14]), 0);
        bar_draw = 1'b1; bar_pixel = 12'h0AB;
        show("bar_over_sprite", 150, 250, 1'b1, 12'h0AB);
        bar_draw = 1'b0;
        show("s1_visible", 120, 100, 1'b1, 12'h0F0);
        rom1 = 12'h00D; show("key1_sky", 120, 100, 1'b1, 12'h006);
        rom1 = 12'h00C; show("key0_sky", 120, 100, 1'b1, 12'h006);
        rom1 = 12'h00F; show("key2_sky", 120, 100, 1'b1, 12'h006);
        rom1 = 12'h0F0;
        rom0 = 12'h00D; show("key_sky_clamp", 150, 250, 1'b1, 12'h00F);
        rom0 = 12'hF00;
        show("ground_c", 16, 400, 1'b1, 12'h0C1);
        show("ground_8", 0, 400, 1'b1, 12'h081);
        show("ground_8b", 16, 408, 1'b1, 12'h081);

        // Mid-frame position change must not show until the next frame
        set_pos(300, 250, 300, 250);
        show("hold_old_pos", 100, 200, 1'b1, 12'hF00);
        show("hold_new_absent", 310, 260, 1'b1, 12'h00F);

        // Frame 2: both sprites at (300,250), full overlap sweep
        new_frame();
        check("f2_count", 32'(overlap_count), 0);
        check("f2_hit", 32'(overlap_hit), 0);
        show("old_pos_gone", 100, 200, 1'b1, 12'h00C);
        for (int v = 250; v < 378; v++) begin
            for (int h = 300; h < 428; h++) begin
                @(negedge clk);
                hCount = 10'(h); vCount = 10'(v); bright = 1'b1; pix_en = 1'b1;
            end
        end
        @(negedge clk);
        pix_en = 1'b0; bright = 1'b0;

        // Frame 3: publish sweep count, check priority
        new_frame();
        check("f3_count", 32'(overlap_count), 16384);
        check("f3_hit", 32'(overlap_hit), 1);
        show("prio_s0", 310, 260, 1'b1, 12'hF00);
        rom0 = 12'h00C; show("prio_s1_through", 310, 260, 1'b1, 12'h0F0);
        rom0 = 12'hF00;

        // Frame 4: sprite0 near right edge; frame 3 had one overlap pixel
        set_pos(1000, 100, 300, 250);
        new_frame();
        check("f4_count", 32'(overlap_count), 1);
        check("f4_hit", 32'(overlap_hit), 1);
        show("edge_first", 1000, 100, 1'b1, 12'hF00);
        show("edge_last", 1023, 100, 1'b1, 12'hF00);
        show("edge_before", 999, 100, 1'b1, 12'h006);
        show("no_wrap", 5, 100, 1'b1, 12'h006);
        px(5, 100, 1'b1, 1'b0);
        check("addr_no_wrap", 32'(sprite_addr[13:0]), 0);
        px(1010, 105, 1'b1, 1'b0);
        check("addr_edge", 32'(sprite_addr[13:0]), 650);

        // Frame 5: no overlaps in frame 4
        new_frame();
        check("f5_count", 32'(overlap_count), 0);
        check("f5_hit", 32'(overlap_hit), 0);

        // Sync delay line
        hsync_in = 1'b0;
        px(50, 50, 1'b0, 1'b0);
        check("hsync_lat1", 32'(hsync_out), 1);
        px(50, 50, 1'b0, 1'b0);
        check("hsync_lat2", 32'(hsync_out), 0);
        hsync_in = 1'b1; vsync_in = 1'b0;
        px(50, 50, 1'b0, 1'b0);
        px(50, 50, 1'b0, 1'b0);
        check("vsync_lat2", 32'(vsync_out), 0);
        check("hsync_back", 32'(hsync_out), 1);
        vsync_in = 1'b1;

        // Flip frame: sprite0 at (200,100), flip requested
        sprite_flip = 2'b01;
        set_pos(200, 100, 300, 250);
        new_frame();
        px(200, 100, 1'b1, 1'b0);
`ifdef SPRITE_HFLIP_EN
        check("flip_addr_a", 32'(sprite_addr[13:0]), 127);
`else
        check("flip_addr_a", 32'(sprite_addr[13:0]), 0);
`endif
        px(201, 101, 1'b1, 1'b0);
`ifdef SPRITE_HFLIP_EN
        check("flip_addr_b", 32'(sprite_addr[13:0]), 254);
`else
        check("flip_addr_b", 32'(sprite_addr[13:0]), 129);
`endif
        sprite_flip = 2'b00;

        // Mid-line reset with non-default outputs
        show("pre_rst_rgb", 210, 110, 1'b1, 12'hF00);
        hsync_in = 1'b0;
        px(210, 110, 1'b1, 1'b0);
        px(210, 110, 1'b1, 1'b0);
        check("pre_rst_hsync", 32'(hsync_out), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rgb", 32'(rgb), 'h000);
        check("mid_rst_hsync", 32'(hsync_out), 1);
        check("mid_rst_addr", 32'(sprite_addr), 0);
        @(negedge clk);
        rst = 1'b0; hsync_in = 1'b1;
        px(16, 400, 1'b1, 1'b0);
        check("refill_black", 32'(rgb), 'h000);
        px(16, 400, 1'b1, 1'b0);
        check("refill_ground", 32'(rgb), 'h0C1);
        show("shadow_reset_origin", 10, 10, 1'b1, 12'hF00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
